johnson_phase_sequencer: RTL
============================

// Module: johnson_phase_sequencer
// PURPOSE
//  Run controller for a twisted-ring (Johnson) counter. Owns a WIDTH-stage Johnson register
//  and steps it a requested number of phases per start command, with hold and abort.
//  Decodes the current state to a one-hot phase enable. Sits between a command source and
//  the phase-enabled datapath it sequences.
// PARAMETERS
//  WIDTH  4  Johnson stages; 2*WIDTH distinct phases (WIDTH>=2)
//  LEN_W  8  width of step-count command
// PORTS
//  clk     in   1          system clock, rising edge
//  reset   in   1          asynchronous, active-low reset
//  start   in   1          command strobe, sampled in IDLE only
//  len     in   LEN_W      phases to step for this command, sampled with start
//  hold    in   1          freeze stepping while 1 (RUN only)
//  abort   in   1          cancel run; priority over hold
//  clr     in   1          sync clear of count to 0, honoured in IDLE only
//  count   out  WIDTH      Johnson register
//  phase   out  2*WIDTH    one-hot decode of count (bit k = step index k)
//  busy    out  1          1 while in RUN
//  done    out  1          1-cycle pulse after last step of a completed command
//  wrap    out  1          1-cycle pulse on the edge count becomes all-zero by stepping
// BEHAVIOUR
//  Reset (reset=0, async): count=0, state=IDLE, remaining=0, busy=0, done=0, wrap=0,
//   phase=1. Takes effect immediately mid-run; no done issued.
//  Forward step: count <= {count[WIDTH-2:0], ~count[WIDTH-1]}.
//   WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000, then 0000 (index 0..7).
//  Index = MSB?(2*WIDTH - ones(count)) : ones(count); phase = 1<<index, combinational.
//  FSM IDLE/RUN/FINISH; all outputs except phase registered.
//   IDLE: start=1,len!=0 at edge E0 -> RUN, remaining=len, busy=1.
//         start=1,len==0 -> FINISH (done=1 next cycle, no step). clr=1 && start=0 -> count=0.
//         clr and start together: start wins, clr ignored.
//   RUN: each edge with abort=0,hold=0: step count, remaining-1. Edge taking remaining 1->0
//         -> FINISH, busy=0, done=1. hold=1: count/remaining frozen, busy stays 1.
//         abort=1: -> IDLE next edge, busy=0, count keeps current value, no done, no step.
//   FINISH: one cycle; done=1; start/clr ignored; -> IDLE, done=0.
//  Latency: len=N without hold -> steps at E1..EN, done high cycle after EN, busy high E0..EN.
//  start/len/clr outside IDLE ignored (no queueing). count persists across commands.
//  remaining is LEN_W bits; len=2^LEN_W-1 is max; count wraps freely (mod 2*WIDTH).
//  wrap=1 for one cycle after any step whose result is all-zero; 0 otherwise.
//  count never leaves the 2*WIDTH legal states (only reset/clr/step write it).
// CONFIGURATION
//  SEQ_REVERSE_EN defined: extra input dir (1 bit), sampled with start, held for the run.
//   dir=1 steps reverse: count <= {~count[0], count[WIDTH-1:1]}
//   (0000->1000->1100->...->0001->0000); wrap on reaching 0 likewise.
//  Undefined: no dir port; forward only.
// TESTING (WIDTH=4, LEN_W=8)
//  1 reset=0 mid-run, count=0111 -> same cycle count=0000, phase=00000001, busy=0, no done.
//  2 From 0000, start len=3 -> count 0001,0011,0111 at E1..E3; busy E0..E3; done 1 cycle
//    after E3; phase=00001000.
//  3 From 0111, start len=10 -> ends 1110 (index 5); wrap pulses once, after 1000->0000.
//  4 len=4, hold=1 two cycles after E2 -> count frozen at 0011, done 2 cycles late;
//    abort at E2 of len=6 -> busy=0, count=0011, no done.
//  5 len=0 -> done pulse, count unchanged; start while busy/FINISH ignored; clr in IDLE -> 0000.
//  6 SEQ_REVERSE_EN, dir=1, from 0000 len=2 -> 1000,1100; wrap=0.

Source files
------------

// File: rtl/johnson_phase_sequencer.sv
// Run controller for a WIDTH-stage Johnson counter: steps it a commanded number of phases
// with hold/abort and decodes it to a one-hot phase. Define SEQ_REVERSE_EN to add a dir input.
module johnson_phase_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 hold,
    input  logic                 abort,
    input  logic                 clr,
`ifdef SEQ_REVERSE_EN
    input  logic                 dir,
`endif
    output logic [WIDTH-1:0]     count,
    output logic [2*WIDTH-1:0]   phase,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap,
    output logic [1:0]           state_dbg
);

    // Handshake: start is a one-cycle strobe accepted only in IDLE (no ready; commands
    // offered while busy or finishing are dropped). done is the single completion pulse.

    localparam int IDX_W = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [WIDTH-1:0]    count_n;
    logic [LEN_W-1:0]    remaining, remaining_n;
    logic                busy_n, done_n, wrap_n;
    logic [WIDTH-1:0]    step_val;
    logic [IDX_W-1:0]    index;

`ifdef SEQ_REVERSE_EN
    logic dir_q, dir_n;

    always_comb begin
        if (dir_q) step_val = {~count[0], count[WIDTH-1:1]};
        else       step_val = {count[WIDTH-2:0], ~count[WIDTH-1]};
    end
`else
    always_comb step_val = {count[WIDTH-2:0], ~count[WIDTH-1]};
`endif

    // Step index from the ones count; states with the MSB set sit in the second half.
    always_comb begin
        int ones;
        int idx;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) ones = ones + int'(count[i]);
        idx   = count[WIDTH-1] ? (2 * WIDTH - ones) : ones;
        index = IDX_W'(idx);
        phase = {{(2*WIDTH-1){1'b0}}, 1'b1} << index;
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        remaining_n = remaining;
        done_n      = 1'b0;
        wrap_n      = 1'b0;
`ifdef SEQ_REVERSE_EN
        dir_n       = dir_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SEQ_REVERSE_EN
                    dir_n = dir;
`endif
                    if (len != '0) begin
                        state_n     = RUN;
                        remaining_n = len;
                    end else begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                    end
                end else if (clr) begin
                    count_n = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (!hold) begin
                    count_n     = step_val;
                    remaining_n = remaining - LEN_W'(1);
                    wrap_n      = (step_val == '0);
                    if (remaining == LEN_W'(1)) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                    end
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
`ifdef SEQ_REVERSE_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            count     <= count_n;
            remaining <= remaining_n;
            busy      <= busy_n;
            done      <= done_n;
            wrap      <= wrap_n;
`ifdef SEQ_REVERSE_EN
            dir_q     <= dir_n;
`endif
        end
    end

    assign state_dbg = state;

endmodule
